artau_burst: RTL

- Parametrised successor of the radar target acquisition unit.
- Emits a configurable burst of PULSES radar pulses and times each echo in clock cycles. Each echo delay is converted to a range.
- Decides threat from first/last range, own-jet travel and a safe-distance limit.
- Sits between the mission controller (scan request, jet speed, limits) and the radar front end (pulse trigger, echo). Adds burst length, cycle-accurate timing, range strobes, lost-target flag and auto-rescan.

---
 rtl/artau_burst.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/artau_burst.sv
// Radar target acquisition burst controller: emits PULSES pulses, times each echo,
// converts delays to ranges and assesses threat from first/last range and own travel.
module artau_burst #(
  parameter int WIDTH          = 32,
  parameter int PULSES         = 2,
  parameter int PULSE_CYCLES   = 300,
  parameter int LISTEN_CYCLES  = 2000,
  parameter int ASSESS_CYCLES  = 3000,
  parameter int DIST_PER_CYCLE = 150,
  parameter int CLK_PERIOD_US  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          scan_for_target,
  input  logic                          auto_rescan,
  input  logic                          radar_echo,
  input  logic [WIDTH-1:0]              jet_speed,
  input  logic [WIDTH-1:0]              max_safe_distance,
  output logic                          radar_pulse_trigger,
  output logic [WIDTH-1:0]              distance_to_target,
  output logic                          distance_valid,
  output logic [$clog2(PULSES+1)-1:0]   pulse_index,
  output logic                          threat_detected,
  output logic                          lost_target,
  output logic [1:0]                    ARTAU_state
);

  localparam int PW    = $clog2(PULSES + 1);
  localparam int MAX_A = (PULSE_CYCLES > LISTEN_CYCLES) ? PULSE_CYCLES : LISTEN_CYCLES;
  localparam int MAX_T = (MAX_A > ASSESS_CYCLES) ? MAX_A : ASSESS_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] EMIT_LAST   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] LISTEN_LAST = TW'(LISTEN_CYCLES - 1);
  localparam logic [TW-1:0] ASSESS_LAST = TW'(ASSESS_CYCLES - 1);
  localparam logic [PW-1:0] FIRST_PULSE = PW'(1);
  localparam logic [PW-1:0] LAST_PULSE  = PW'(PULSES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_LISTEN = 2'd2,
    S_ASSESS = 2'd3
  } state_t;

  state_t            state_reg,   state_next;
  logic [TW-1:0]     timer_reg,   timer_next;
  logic [PW-1:0]     pulse_reg,   pulse_next;
  logic [WIDTH-1:0]  elapsed_reg, elapsed_next;
  logic [WIDTH-1:0]  d_first_reg, d_first_next;
  logic [WIDTH-1:0]  dist_reg,    dist_next;
  logic              valid_reg,   valid_next;
  logic              threat_reg,  threat_next;
  logic              lost_reg,    lost_next;
  logic              scan_prev_reg;
  logic              echo_prev_reg;

  logic                    scan_edge;
  logic                    echo_edge;
  logic [2*WIDTH-1:0]      range_full;
  logic [WIDTH-1:0]        range_sat;
  logic [WIDTH-1:0]        elapsed_inc;
  logic                    counting;
  logic [3*WIDTH-1:0]      own_prod;
  logic [WIDTH:0]          own;
  logic signed [WIDTH+1:0] rel;
  logic                    threat_calc;

  assign scan_edge = scan_for_target & ~scan_prev_reg;
  assign echo_edge = radar_echo & ~echo_prev_reg;

  assign range_full  = (2*WIDTH)'(timer_reg) * (2*WIDTH)'(DIST_PER_CYCLE);
  assign range_sat   = (|range_full[2*WIDTH-1:WIDTH]) ? '1 : range_full[WIDTH-1:0];
  assign elapsed_inc = (&elapsed_reg) ? elapsed_reg : elapsed_reg + WIDTH'(1);

  // The elapsed window opens on the first LISTEN cycle of pulse 1, so pulse-1 EMIT is excluded.
  assign counting = (state_reg == S_LISTEN) ||
                    ((state_reg == S_EMIT) && (pulse_reg != FIRST_PULSE));

  // The final-echo cycle itself is counted, hence elapsed_inc rather than elapsed_reg.
  assign own_prod    = (3*WIDTH)'(jet_speed) * (3*WIDTH)'(elapsed_inc) * (3*WIDTH)'(CLK_PERIOD_US);
  assign own         = (WIDTH+1)'(own_prod / (3*WIDTH)'(1_000_000));
  assign rel         = (WIDTH+2)'(range_sat) + (WIDTH+2)'(own) - (WIDTH+2)'(d_first_reg);
  assign threat_calc = (range_sat < max_safe_distance) && rel[WIDTH+1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      timer_reg     <= '0;
      pulse_reg     <= '0;
      elapsed_reg   <= '0;
      d_first_reg   <= '0;
      dist_reg      <= '0;
      valid_reg     <= 1'b0;
      threat_reg    <= 1'b0;
      lost_reg      <= 1'b0;
      scan_prev_reg <= 1'b0;
      echo_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      pulse_reg     <= pulse_next;
      elapsed_reg   <= elapsed_next;
      d_first_reg   <= d_first_next;
      dist_reg      <= dist_next;
      valid_reg     <= valid_next;
      threat_reg    <= threat_next;
      lost_reg      <= lost_next;
      scan_prev_reg <= scan_for_target;
      echo_prev_reg <= radar_echo;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    pulse_next   = pulse_reg;
    elapsed_next = counting ? elapsed_inc : elapsed_reg;
    d_first_next = d_first_reg;
    dist_next    = dist_reg;
    valid_next   = 1'b0;
    threat_next  = threat_reg;
    lost_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (scan_edge) begin
          state_next   = S_EMIT;
          pulse_next   = FIRST_PULSE;
          timer_next   = '0;
          elapsed_next = '0;
        end
      end
      S_EMIT: begin
        if (timer_reg == EMIT_LAST) begin
          state_next = S_LISTEN;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      S_LISTEN: begin
        // An echo on the last listen cycle is checked first so it beats the timeout.
        if (echo_edge) begin
          dist_next  = range_sat;
          valid_next = 1'b1;
          timer_next = '0;
          if (pulse_reg == FIRST_PULSE) begin
            d_first_next = range_sat;
          end
          if (pulse_reg != LAST_PULSE) begin
            state_next = S_EMIT;
            pulse_next = pulse_reg + PW'(1);
          end else begin
            state_next  = S_ASSESS;
            threat_next = threat_calc;
          end
        end else if (timer_reg == LISTEN_LAST) begin
          state_next = S_IDLE;
          dist_next  = '0;
          lost_next  = 1'b1;
          pulse_next = '0;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      S_ASSESS: begin
        if (scan_edge || ((timer_reg == ASSESS_LAST) && auto_rescan)) begin
          state_next   = S_EMIT;
          pulse_next   = FIRST_PULSE;
          timer_next   = '0;
          elapsed_next = '0;
        end else if (timer_reg == ASSESS_LAST) begin
          state_next = S_IDLE;
          dist_next  = '0;
          pulse_next = '0;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign radar_pulse_trigger = (state_reg == S_EMIT);
  assign distance_to_target  = dist_reg;
  assign distance_valid      = valid_reg;
  assign pulse_index         = pulse_reg;
  assign threat_detected     = threat_reg;
  assign lost_target         = lost_reg;
  assign ARTAU_state         = state_reg;

endmodule
